// File: rtl/mac16_pkg.sv
// Shared types, encodings and operand-extension helpers for the mac16 DSP slice.
package mac16_pkg;

  typedef logic [15:0] operand_t;
  typedef logic [31:0] product_t;
  typedef logic [32:0] sum_t;

  // Encodings for the signedness and multiplier-mode parameters.
  localparam bit OPND_SIGNED   = 1'b1;
  localparam bit MODE_DUAL_8X8 = 1'b1;

  // Number of input operand lanes (A, B, C, D), in that index order.
  localparam int NUM_IN = 4;

  // Sign- or zero-extend a 16-bit operand to 32 bits.
  function automatic product_t ext32(input operand_t v, input bit sgn);
    return {{16{sgn & v[15]}}, v};
  endfunction

  // Sign- or zero-extend a byte operand to 16 bits.
  function automatic logic [15:0] ext16(input logic [7:0] v, input bit sgn);
    return {{8{sgn & v[7]}}, v};
  endfunction

endpackage

// File: rtl/mac16_dsp_if.sv
// Operand, control and result bundle of the mac16 DSP slice.
interface mac16_dsp_if;
  import mac16_pkg::*;

  logic     ce;
  operand_t a;
  operand_t b;
  operand_t c;
  operand_t d;
  logic     ahold;
  logic     bhold;
  logic     chold;
  logic     dhold;
  logic     addsub;
  logic     oload;
  logic     ohold;
  logic     ci;
  product_t o;
  logic     co;
  logic     accumco;
  logic     signextout;

  modport master (
    output ce, a, b, c, d, ahold, bhold, chold, dhold, addsub, oload, ohold, ci,
    input  o, co, accumco, signextout
  );

  modport slave (
    input  ce, a, b, c, d, ahold, bhold, chold, dhold, addsub, oload, ohold, ci,
    output o, co, accumco, signextout
  );

endinterface

// File: rtl/mac16_mult.sv
// Combinational multiplier: one 16x16 product or two independent 8x8 products.
module mac16_mult
  import mac16_pkg::*;
#(
  parameter bit A_SIGNED = 1'b0,
  parameter bit B_SIGNED = 1'b0,
  parameter bit MODE_8x8 = 1'b0
) (
  input  operand_t a,
  input  operand_t b,
  output product_t p
);

  generate
    if (MODE_8x8 == MODE_DUAL_8X8) begin : g_dual
      logic [15:0] at;
      logic [15:0] bt;
      logic [15:0] pt;
      logic [15:0] pb;
      // Upper bytes honour signedness; lower bytes are always unsigned; no carry between halves.
      always_comb begin
        at = ext16(a[15:8], A_SIGNED);
        bt = ext16(b[15:8], B_SIGNED);
        pt = at * bt;
        pb = {8'h00, a[7:0]} * {8'h00, b[7:0]};
        p  = {pt, pb};
      end
    end else begin : g_single
      // Full product of the extended operands, kept modulo 2^32.
      always_comb begin
        p = ext32(a, A_SIGNED) * ext32(b, B_SIGNED);
      end
    end
  endgenerate

endmodule

// File: rtl/mac16_dsp.sv
// 16x16 / dual 8x8 multiply-add/accumulate slice with optional input and output registers.
module mac16_dsp
  import mac16_pkg::*;
#(
  parameter bit A_SIGNED = 1'b0,
  parameter bit B_SIGNED = 1'b0,
  parameter bit MODE_8x8 = 1'b0,
  parameter bit A_REG    = 1'b0,
  parameter bit B_REG    = 1'b0,
  parameter bit C_REG    = 1'b0,
  parameter bit D_REG    = 1'b0,
  parameter bit OUT_REG  = 1'b1,
  parameter bit ACCUM    = 1'b0
) (
  input logic        clk,
  input logic        rst,
  mac16_dsp_if.slave bus
);

  localparam bit [NUM_IN-1:0] IN_REG = {D_REG, C_REG, B_REG, A_REG};

  operand_t          in_raw [NUM_IN];
  operand_t          in_v   [NUM_IN];
  logic [NUM_IN-1:0] in_hold;

  assign in_raw[0] = bus.a;
  assign in_raw[1] = bus.b;
  assign in_raw[2] = bus.c;
  assign in_raw[3] = bus.d;
  assign in_hold   = {bus.dhold, bus.chold, bus.bhold, bus.ahold};

  // Each lane has a register; unregistered lanes select the raw input and the flop is pruned.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_in
      operand_t in_q;
      operand_t in_d;
      // Load the lane register only when enabled and not held.
      always_comb begin
        in_d = in_q;
        if (bus.ce && !in_hold[gi]) in_d = in_raw[gi];
      end
      // Lane register; reset wins over enable and hold.
      always_ff @(posedge clk) begin
        if (rst) in_q <= '0;
        else     in_q <= in_d;
      end
      assign in_v[gi] = IN_REG[gi] ? in_q : in_raw[gi];
    end
  endgenerate

  product_t p;
  product_t z;
  product_t dc;
  sum_t     sum;
  product_t o_q;
  product_t o_d;
  logic     co_q;
  logic     co_d;
  product_t o_w;
  logic     co_w;

  mac16_mult #(
    .A_SIGNED (A_SIGNED),
    .B_SIGNED (B_SIGNED),
    .MODE_8x8 (MODE_8x8)
  ) u_mult (
    .a (in_v[0]),
    .b (in_v[1]),
    .p (p)
  );

  assign dc = {in_v[3], in_v[2]};

  // 33-bit add/subtract over the full 32-bit chain; bit 32 is carry (add) or borrow (subtract).
  always_comb begin
    z = ACCUM ? o_q : dc;
    if (bus.addsub) sum = {1'b0, p} - {1'b0, z} - {32'b0, bus.ci};
    else            sum = {1'b0, p} + {1'b0, z} + {32'b0, bus.ci};
  end

  // Output register next state: enable, then direct load, then hold, then adder result.
  always_comb begin
    o_d  = o_q;
    co_d = co_q;
    if (bus.ce) begin
      if (bus.oload) begin
        o_d  = dc;
        co_d = 1'b0;
      end else if (!bus.ohold) begin
        o_d  = sum[31:0];
        co_d = sum[32];
      end
    end
  end

  // Output and carry registers; the accumulator feedback always comes from here.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_q  <= '0;
      co_q <= 1'b0;
    end else begin
      o_q  <= o_d;
      co_q <= co_d;
    end
  end

  assign o_w            = OUT_REG ? o_q : sum[31:0];
  assign co_w           = OUT_REG ? co_q : sum[32];
  assign bus.o          = o_w;
  assign bus.co         = co_w;
  assign bus.accumco    = ACCUM ? co_w : 1'b0;
  assign bus.signextout = o_w[31];

endmodule

// File: tb/tb_mac16_dsp.sv
// Self-checking bench for mac16_dsp: four configurations checked through a result scoreboard.
module tb_mac16_dsp;

  logic clk;
  logic rst;

  mac16_dsp_if bus0 ();  // 16x16 signed
  mac16_dsp_if bus1 ();  // dual 8x8 signed
  mac16_dsp_if bus2 ();  // accumulator
  mac16_dsp_if bus3 ();  // registered A

  mac16_dsp #(.A_SIGNED(1'b1), .B_SIGNED(1'b1)) u_s16 (.clk(clk), .rst(rst), .bus(bus0));
  mac16_dsp #(.A_SIGNED(1'b1), .B_SIGNED(1'b1), .MODE_8x8(1'b1)) u_d8 (.clk(clk), .rst(rst), .bus(bus1));
  mac16_dsp #(.ACCUM(1'b1)) u_acc (.clk(clk), .rst(rst), .bus(bus2));
  mac16_dsp #(.A_REG(1'b1)) u_areg (.clk(clk), .rst(rst), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] o;
    logic        co;
  } exp_t;

  typedef struct {
    logic [15:0] a, b, c, d;
    logic        addsub, ci;
    logic [31:0] eo;
    logic        eco;
  } vec_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_all();
    bus0.ce = 1; bus0.a = 0; bus0.b = 0; bus0.c = 0; bus0.d = 0; bus0.addsub = 0; bus0.ci = 0;
    bus0.ahold = 0; bus0.bhold = 0; bus0.chold = 0; bus0.dhold = 0; bus0.oload = 0; bus0.ohold = 0;
    bus1.ce = 1; bus1.a = 0; bus1.b = 0; bus1.c = 0; bus1.d = 0; bus1.addsub = 0; bus1.ci = 0;
    bus1.ahold = 0; bus1.bhold = 0; bus1.chold = 0; bus1.dhold = 0; bus1.oload = 0; bus1.ohold = 0;
    bus2.ce = 1; bus2.a = 0; bus2.b = 0; bus2.c = 0; bus2.d = 0; bus2.addsub = 0; bus2.ci = 0;
    bus2.ahold = 0; bus2.bhold = 0; bus2.chold = 0; bus2.dhold = 0; bus2.oload = 0; bus2.ohold = 0;
    bus3.ce = 1; bus3.a = 0; bus3.b = 0; bus3.c = 0; bus3.d = 0; bus3.addsub = 0; bus3.ci = 0;
    bus3.ahold = 0; bus3.bhold = 0; bus3.chold = 0; bus3.dhold = 0; bus3.oload = 0; bus3.ohold = 0;
  endtask

  // Reset with live, nonzero inputs: every configuration must come up at zero.
  task automatic test_reset();
    logic [31:0] os [4];
    logic        cs [4];
    init_all();
    bus0.a = 16'h0005; bus0.b = 16'h0003; bus0.c = 16'h0009;
    bus1.a = 16'h0005; bus1.b = 16'h0003; bus1.c = 16'h0009;
    bus2.a = 16'h0002; bus2.b = 16'h0003;
    bus3.a = 16'h0004; bus3.b = 16'h0005;
    rst = 1'b1;
    tick();
    tick();
    os[0] = bus0.o; os[1] = bus1.o; os[2] = bus2.o; os[3] = bus3.o;
    cs[0] = bus0.co; cs[1] = bus1.co; cs[2] = bus2.co; cs[3] = bus3.co;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (os[i] !== 32'h0 || cs[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_dut%0d: got o=%h co=%b, want o=00000000 co=0", i, os[i], cs[i]);
      end
      $display("txn reset dut%0d: o=%h co=%b", i, os[i], cs[i]);
    end
    rst = 1'b0;
    init_all();
  endtask

  // 16x16 signed products: fixed corner vectors then random vectors against an arithmetic model.
  task automatic test_signed16();
    vec_t vt [5];
    exp_t e;
    vt[0] = '{16'hFFFE, 16'd300, 16'h0, 16'h0, 1'b0, 1'b0, 32'hFFFF_FDA8, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 16'h0001, 16'h0, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
    vt[2] = '{16'h8000, 16'h8000, 16'h0, 16'h0, 1'b0, 1'b0, 32'h4000_0000, 1'b0};
    vt[3] = '{16'h7FFF, 16'hFFFF, 16'h0, 16'h0, 1'b0, 1'b0, 32'hFFFF_8001, 1'b0};
    vt[4] = '{16'h0003, 16'h0004, 16'h0005, 16'h0, 1'b0, 1'b1, 32'h0000_0012, 1'b0};
    for (int i = 0; i < 13; i++) begin
      logic [15:0] ra, rb, rc, rd;
      logic        rs, rci;
      if (i < 5) begin
        ra = vt[i].a; rb = vt[i].b; rc = vt[i].c; rd = vt[i].d; rs = vt[i].addsub; rci = vt[i].ci;
        e.o = vt[i].eo; e.co = vt[i].eco;
      end else begin
        longint      pa, pb, pp;
        logic [32:0] s;
        ra = 16'($urandom); rb = 16'($urandom); rc = 16'($urandom); rd = 16'($urandom);
        rs = 1'($urandom); rci = 1'($urandom);
        pa = longint'($signed(ra));
        pb = longint'($signed(rb));
        pp = pa * pb;
        if (rs) s = {1'b0, pp[31:0]} - {1'b0, rd, rc} - {32'b0, rci};
        else    s = {1'b0, pp[31:0]} + {1'b0, rd, rc} + {32'b0, rci};
        e.o = s[31:0]; e.co = s[32];
      end
      bus0.a = ra; bus0.b = rb; bus0.c = rc; bus0.d = rd; bus0.addsub = rs; bus0.ci = rci;
      sb_q.push_back(e);
      tick();
      e = sb_q.pop_front();
      n_cmp++;
      if (bus0.o !== e.o || bus0.co !== e.co || bus0.signextout !== e.o[31] || bus0.accumco !== 1'b0) begin
        n_bad++;
        $display("FAIL signed16[%0d]: got o=%h co=%b sx=%b ac=%b, want o=%h co=%b sx=%b ac=0",
                 i, bus0.o, bus0.co, bus0.signextout, bus0.accumco, e.o, e.co, e.o[31]);
      end
      $display("txn signed16[%0d]: a=%h b=%h c=%h d=%h sub=%b ci=%b o=%h co=%b", i, ra, rb, rc, rd, rs, rci, bus0.o, bus0.co);
    end
    init_all();
  endtask

  // Subtraction with borrow, carry-in, then direct load and output hold.
  task automatic test_subtract();
    vec_t vt [4];
    exp_t e;
    vt[0] = '{16'd7, 16'd6, 16'd2, 16'h0, 1'b1, 1'b0, 32'd40, 1'b0};
    vt[1] = '{16'd7, 16'd6, 16'd50, 16'h0, 1'b1, 1'b0, 32'hFFFF_FFF8, 1'b1};
    vt[2] = '{16'd7, 16'd6, 16'd2, 16'h0, 1'b1, 1'b1, 32'd39, 1'b0};
    vt[3] = '{16'd0, 16'd0, 16'd0, 16'h0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1};
    for (int i = 0; i < 6; i++) begin
      bus0.oload = 1'b0; bus0.ohold = 1'b0;
      if (i < 4) begin
        bus0.a = vt[i].a; bus0.b = vt[i].b; bus0.c = vt[i].c; bus0.d = vt[i].d;
        bus0.addsub = vt[i].addsub; bus0.ci = vt[i].ci;
        e.o = vt[i].eo; e.co = vt[i].eco;
      end else if (i == 4) begin
        bus0.oload = 1'b1; bus0.d = 16'h1234; bus0.c = 16'h5678;
        e.o = 32'h1234_5678; e.co = 1'b0;
      end else begin
        bus0.ohold = 1'b1; bus0.a = 16'd9; bus0.b = 16'd9; bus0.c = 16'd0; bus0.d = 16'd0;
        e.o = 32'h1234_5678; e.co = 1'b0;
      end
      sb_q.push_back(e);
      tick();
      e = sb_q.pop_front();
      n_cmp++;
      if (bus0.o !== e.o || bus0.co !== e.co) begin
        n_bad++;
        $display("FAIL subtract[%0d]: got o=%h co=%b, want o=%h co=%b", i, bus0.o, bus0.co, e.o, e.co);
      end
      $display("txn subtract[%0d]: oload=%b ohold=%b o=%h co=%b", i, bus0.oload, bus0.ohold, bus0.o, bus0.co);
    end
    init_all();
  endtask

  // Dual 8x8: signed upper bytes, unsigned lower bytes, full carry chain in the adder.
  task automatic test_dual8x8();
    vec_t vt [5];
    exp_t e;
    vt[0] = '{16'd5, 16'd3, 16'd10, 16'h0, 1'b0, 1'b0, 32'd25, 1'b0};
    vt[1] = '{16'hFE05, 16'h0303, 16'h0, 16'h0, 1'b0, 1'b0, 32'hFFFA_000F, 1'b0};
    vt[2] = '{16'h00FF, 16'h00FF, 16'h0, 16'h0, 1'b0, 1'b0, 32'h0000_FE01, 1'b0};
    vt[3] = '{16'h00FF, 16'h00FF, 16'h01FF, 16'h0, 1'b0, 1'b0, 32'h0001_0000, 1'b0};
    vt[4] = '{16'h8000, 16'h8000, 16'h0, 16'h0, 1'b0, 1'b0, 32'h4000_0000, 1'b0};
    for (int i = 0; i < 5; i++) begin
      bus1.a = vt[i].a; bus1.b = vt[i].b; bus1.c = vt[i].c; bus1.d = vt[i].d;
      bus1.addsub = vt[i].addsub; bus1.ci = vt[i].ci;
      e.o = vt[i].eo; e.co = vt[i].eco;
      sb_q.push_back(e);
      tick();
      e = sb_q.pop_front();
      n_cmp++;
      if (bus1.o !== e.o || bus1.co !== e.co) begin
        n_bad++;
        $display("FAIL dual8x8[%0d]: got o=%h co=%b, want o=%h co=%b", i, bus1.o, bus1.co, e.o, e.co);
      end
      $display("txn dual8x8[%0d]: a=%h b=%h c=%h o=%h", i, vt[i].a, vt[i].b, vt[i].c, bus1.o);
    end
    init_all();
  endtask

  // Accumulator: seed, accumulate, hold, clock-enable freeze, wrap with carry out.
  task automatic test_accum();
    exp_t        e;
    logic [32:0] acc;
    logic        acc_co;
    acc = '0;
    acc_co = 1'b0;
    for (int i = 0; i < 13; i++) begin
      bus2.oload = 1'b0; bus2.ohold = 1'b0; bus2.ce = 1'b1;
      bus2.a = 16'd2; bus2.b = 16'd3; bus2.c = 16'd0; bus2.d = 16'd0;
      case (i)
        0:       begin bus2.oload = 1'b1; bus2.c = 16'd1; end
        5, 6:    bus2.ohold = 1'b1;
        7, 8:    bus2.ce = 1'b0;
        10:      begin bus2.oload = 1'b1; bus2.c = 16'hFFFF; bus2.d = 16'hFFFF; end
        11:      begin bus2.a = 16'd1; bus2.b = 16'd1; end
        12:      bus2.ohold = 1'b1;
        default: ;
      endcase
      if (bus2.ce) begin
        if (bus2.oload) begin
          acc = {1'b0, bus2.d, bus2.c}; acc_co = 1'b0;
        end else if (!bus2.ohold) begin
          acc = {1'b0, acc[31:0]} + 33'(bus2.a * bus2.b); acc_co = acc[32];
        end
      end
      e.o = acc[31:0]; e.co = acc_co;
      sb_q.push_back(e);
      tick();
      e = sb_q.pop_front();
      n_cmp++;
      if (bus2.o !== e.o || bus2.co !== e.co || bus2.accumco !== e.co) begin
        n_bad++;
        $display("FAIL accum[%0d]: got o=%h co=%b ac=%b, want o=%h co=%b ac=%b",
                 i, bus2.o, bus2.co, bus2.accumco, e.o, e.co, e.co);
      end
      $display("txn accum[%0d]: ce=%b oload=%b ohold=%b o=%0d co=%b", i, bus2.ce, bus2.oload, bus2.ohold, bus2.o, bus2.co);
    end
    init_all();
  endtask

  // Registered A with hold: o follows the held register value, while B stays combinational.
  task automatic test_ahold();
    logic [15:0] a_m;
    logic [15:0] av [7];
    logic [15:0] bv [7];
    logic        hv [7];
    exp_t        e;
    a_m = 16'd0;
    av = '{16'd4, 16'd4, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9};
    bv = '{16'd5, 16'd5, 16'd5, 16'd5, 16'd6, 16'd6, 16'd6};
    hv = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      bus3.a = av[i]; bus3.b = bv[i]; bus3.ahold = hv[i];
      e.o = 32'(a_m) * 32'(bv[i]); e.co = 1'b0;
      if (!hv[i]) a_m = av[i];
      sb_q.push_back(e);
      tick();
      e = sb_q.pop_front();
      n_cmp++;
      if (bus3.o !== e.o || bus3.co !== e.co) begin
        n_bad++;
        $display("FAIL ahold[%0d]: got o=%0d co=%b, want o=%0d co=%b", i, bus3.o, bus3.co, e.o, e.co);
      end
      $display("txn ahold[%0d]: a=%0d b=%0d ahold=%b o=%0d", i, av[i], bv[i], hv[i], bus3.o);
    end
  endtask

  // Reset in mid-operation overrides ce and holds, and also clears the input registers.
  task automatic test_reset_mid();
    bus0.a = 16'd7; bus0.b = 16'd6; bus0.c = 16'd50; bus0.addsub = 1'b1;
    tick();
    n_cmp++;
    if (bus0.o !== 32'hFFFF_FFF8 || bus0.co !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_pre: got o=%h co=%b, want o=fffffff8 co=1", bus0.o, bus0.co);
    end
    $display("txn reset_mid pre: o=%h co=%b", bus0.o, bus0.co);
    bus0.ce = 1'b0; bus0.ohold = 1'b1; bus3.ce = 1'b0; bus3.ahold = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (bus0.o !== 32'h0 || bus0.co !== 1'b0 || bus3.o !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_mid: got o=%h co=%b areg_o=%h, want all zero", bus0.o, bus0.co, bus3.o);
    end
    $display("txn reset_mid: o=%h co=%b areg_o=%h", bus0.o, bus0.co, bus3.o);
    init_all();
    bus3.a = 16'd3; bus3.b = 16'd2;
    tick();
    n_cmp++;
    if (bus3.o !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_mid_areg: got o=%0d, want 0 (A register cleared)", bus3.o);
    end
    $display("txn reset_mid areg: o=%0d", bus3.o);
    tick();
    n_cmp++;
    if (bus3.o !== 32'd6) begin
      n_bad++;
      $display("FAIL reset_mid_areg2: got o=%0d, want 6", bus3.o);
    end
    $display("txn reset_mid areg2: o=%0d", bus3.o);
  endtask

  initial begin
    rst = 1'b1;
    init_all();
    test_reset();
    test_signed16();
    test_subtract();
    test_dual8x8();
    test_accum();
    test_ahold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
